cascadable_counter_slice: RTL
=============================

// Module: cascadable_counter_slice
// PURPOSE
//  Parametrised, registered successor of the 4-bit loadable counter-slice next-state logic.
//  Holds the count in flops. Supports:
//   - synchronous clear and parallel load
//   - up/down counting with a programmable modulus
//   - two-level count enable (en_p/en_t) and a terminal-count output, for ripple-free cascading of N slices
//   - registered wrap pulse and a sticky overflow flag, for timer/prescaler chains
// PARAMETERS
//  WIDTH       4    count/load width in bits (>=1)
//  MODULUS     16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  RESET_VALUE 0    q value after reset; must be < MODULUS
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  clr      in   1      synchronous clear (highest priority)
//  ld       in   1      synchronous parallel load of d
//  d        in   WIDTH  load data
//  en_p     in   1      parallel count enable (local)
//  en_t     in   1      trickle count enable (from previous slice's tc; also gates tc)
//  up       in   1      1 = count up, 0 = count down
//  q        out  WIDTH  current count (registered)
//  tc       out  1      terminal count, combinational: en_t & (up ? q==MODULUS-1 : q==0)
//  wrap     out  1      registered 1-cycle pulse: q wrapped on the previous edge
//  ovf      out  1      sticky: set on any wrap, cleared by clr or reset
// BEHAVIOUR
//  Reset (rst_n=0, async, regardless of clk): q=RESET_VALUE, wrap=0, ovf=0.
//   - tc follows from q and en_t.
//   - Deassertion takes effect on the next rising edge.
//  Per rising edge, the priority is clr > ld > count > hold.
//   - clr=1: q<=0, wrap<=0, ovf<=0. ld and count are ignored.
//   - ld=1 (clr=0): q <= (d >= MODULUS) ? MODULUS-1 : d.
//     - Load is a clamp, not modulo.
//     - wrap<=0; ovf holds.
//   - count (clr=0, ld=0, en_p=1, en_t=1):
//     - up=1: q<=q+1; if q==MODULUS-1 then q<=0 and wrap<=1.
//     - up=0: q<=q-1; if q==0 then q<=MODULUS-1 and wrap<=1.
//     - A wrap sets ovf<=1.
//   - hold (otherwise): q holds; wrap<=0; ovf holds.
//  Latency and enables:
//   - q changes exactly one edge after the qualifying input.
//   - wrap is high for exactly the cycle after a wrap edge.
//   - en_p low does not gate tc; en_t low forces tc=0.
//  Arithmetic:
//   - Internal next-state is computed in WIDTH+1 bits.
//   - No value >= MODULUS is ever stored, even when MODULUS < 2**WIDTH.
//  Direction: a change of up takes effect on the same edge's count; tc updates combinationally.
//  Cascading:
//   - Slice k: en_t[k] = tc[k-1], and en_p is shared across slices.
//   - All slices share clk/clr/ld/up.
//   - The chain therefore counts as one WIDTH*N counter of base MODULUS.
//  No X on outputs after reset.
//   - Inputs other than clk/rst_n are sampled only at rising edges.
//   - Glitches between edges affect tc only.
// TESTING
//  1. Reset mid-count (WIDTH=4, MODULUS=16, q=9): assert rst_n=0 between edges -> q=0, wrap=0, ovf=0 immediately, without waiting for an edge.
//  2. Up wrap (MODULUS=10, up=1, en_p=en_t=1, from q=8):
//     - Edges give q=9, then q=0.
//     - tc=1 while q=9; wrap=1 for exactly the cycle after 9->0; ovf=1 afterwards.
//  3. Down wrap (MODULUS=10, up=0, q=1):
//     - Edges give q=0 (tc=1), then q=9, with a wrap pulse.
//     - Then clr=1 -> q=0, ovf=0.
//  4. Priority:
//     - clr=1 & ld=1 & d=5 -> q=0.
//     - ld=1 & d=13 with MODULUS=10 -> q=9 (clamp), no wrap pulse.
//     - ld=1 with en_p=en_t=1 -> load wins.
//  5. Enables: en_p=0, en_t=1 at q=15 (up) -> q holds, tc=1. en_t=0 -> tc=0, q holds.
//  6. Cascade of two slices (MODULUS=16):
//     - Starting at 0x0F, one edge gives 0x10.
//     - Starting at 0xFF, one edge gives 0x00, with wrap on both slices and tc_high=0 afterwards.
//     - Random up/down/ld/clr runs are checked against a reference model for 10k cycles.

Source files
------------

// File: rtl/cascadable_counter_slice.sv
// cascadable_counter_slice: registered modulo up/down counter slice with
// clamped load, two-level enable, terminal count, wrap pulse and sticky ovf.
module cascadable_counter_slice #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en_p,
  input  logic             en_t,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH:0] MOD_X =
    (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] TOP_X =
    (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP =
    TOP_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q =
    WIDTH'(RESET_VALUE);

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   d_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic             at_top;
  logic             at_zero;
  logic             cnt;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign q_x     = {1'b0, q};
  assign d_x     = {1'b0, d};
  assign inc_x   = q_x + (WIDTH+1)'(1);
  assign dec_x   = q_x - (WIDTH+1)'(1);
  assign at_top  = (q_x == TOP_X);
  assign at_zero = (q_x == '0);
  assign cnt     = en_p & en_t;

  assign tc = en_t & (up ? at_top : at_zero);

  // Wrap is detected on the extended sum/borrow so no
  // out-of-range value can ever reach the register.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (ld) begin
      q_nxt = (d_x >= MOD_X) ? TOP : d;
    end else if (cnt) begin
      if (up) begin
        if (inc_x == MOD_X) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = inc_x[WIDTH-1:0];
        end
      end else begin
        if (dec_x[WIDTH]) begin
          q_nxt    = TOP;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = dec_x[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RST_Q;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      if (wrap_nxt) ovf <= 1'b1;
    end
  end

endmodule
